// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Shared constants, FSM state type and helpers for the count display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam int BCD_W = 4;
    localparam int BIN_W = 7;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_enc(input logic [BCD_W-1:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] digit);
        return (digit >= 4'd5) ? BCD_W'(digit + 4'd3) : digit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_count_display_if.sv
// ============================================================================
// Module : seg7_count_display_if
// Brief  : Count input and display-side signals of the 2-digit count display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_count_display_if;
    logic [6:0] count_in;
    logic       busy;
    logic       ovf;
    logic [6:0] seg_n;
    logic [1:0] an_n;

    modport master (
        output count_in,
        input  busy,
        input  ovf,
        input  seg_n,
        input  an_n
    );

    modport slave (
        input  count_in,
        output busy,
        output ovf,
        output seg_n,
        output an_n
    );
endinterface

`default_nettype wire

// File: rtl/seg7_count_display_bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Sequential 7-bit to 2-digit BCD converter (shift-add-3, 7 shifts).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import traffic_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic [BIN_W-1:0] bin,
    output logic                  busy,
    output logic                  done,
    output logic [BCD_W-1:0]      tens,
    output logic [BCD_W-1:0]      ones
);

    conv_state_t  state_q, state_d;
    logic [14:0]  sh_q, sh_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [14:0]  adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift register layout: [14:11]=tens, [10:7]=ones, [6:0]=binary
    assign adj = {add3(sh_q[14:11]), add3(sh_q[10:7]), sh_q[6:0]};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = {8'd0, bin};
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                sh_d  = adj << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign tens = sh_q[14:11];
    assign ones = sh_q[10:7];

endmodule

`default_nettype wire

// File: rtl/seg7_count_display.sv
// ============================================================================
// Module : seg7_count_display
// Brief  : Binary second count to multiplexed 2-digit common-anode display.
//          Optional macro SEG7_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_count_display
    import traffic_pkg::*;
#(
    parameter int pSCAN_DIV = 1000,
    parameter int pMAX_DISP = 99
) (
    input  wire logic           clk,
    input  wire logic           rst,
    seg7_count_display_if.slave bus
);

    localparam int                PS_W    = (pSCAN_DIV > 1) ? $clog2(pSCAN_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(pSCAN_DIV - 1);
    localparam logic [BIN_W-1:0]  MAX7    = BIN_W'(pMAX_DISP);

    logic [BIN_W-1:0] count_q;
    logic             q_valid;
    logic             force_conv;
    logic [BIN_W-1:0] last_q;
    logic [BIN_W-1:0] latched_q;
    logic [BCD_W-1:0] tens, ones;
    logic             ovf;
    logic [PS_W-1:0]  prescaler;
    logic             sel;
    logic [6:0]       seg_n;
    logic [1:0]       an_n;

    logic             start;
    logic [BIN_W-1:0] conv_src;
    logic             conv_busy, conv_done;
    logic [BCD_W-1:0] conv_tens, conv_ones;
    logic [6:0]       tens_seg;

    assign conv_src = (count_q > MAX7) ? MAX7 : count_q;
    // q_valid holds off the forced first conversion until count_q holds a real sample
    assign start    = q_valid && !conv_busy && (force_conv || (count_q != last_q));

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (conv_src),
        .busy  (conv_busy),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            q_valid    <= 1'b0;
            force_conv <= 1'b1;
            last_q     <= '0;
            latched_q  <= '0;
            tens       <= '0;
            ones       <= '0;
            ovf        <= 1'b0;
        end else begin
            count_q <= bus.count_in;
            q_valid <= 1'b1;
            if (start) begin
                latched_q <= count_q;
            end
            if (conv_done) begin
                tens       <= conv_tens;
                ones       <= conv_ones;
                ovf        <= (latched_q > MAX7);
                last_q     <= latched_q;
                force_conv <= 1'b0;
            end
        end
    end

`ifdef SEG7_BLANK_LEADING_ZERO_EN
    assign tens_seg = (tens == '0) ? SEG_OFF : seg_enc(tens);
`else
    assign tens_seg = seg_enc(tens);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            sel       <= 1'b0;
            seg_n     <= SEG_OFF;
            an_n      <= 2'b11;
        end else begin
            if (prescaler == PS_LAST) begin
                prescaler <= '0;
                sel       <= ~sel;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            seg_n <= sel ? tens_seg : seg_enc(ones);
            an_n  <= sel ? 2'b01 : 2'b10;
        end
    end

    assign bus.busy  = conv_busy;
    assign bus.ovf   = ovf;
    assign bus.seg_n = seg_n;
    assign bus.an_n  = an_n;

endmodule

`default_nettype wire

// File: tb/tb_seg7_count_display.sv
// ============================================================================
// Module : tb_seg7_count_display
// Brief  : Directed self-checking bench for seg7_count_display (scan div 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_count_display;

    localparam int SCAN = 4;

    localparam logic [6:0] S0   = 7'h40;
    localparam logic [6:0] S1   = 7'h79;
    localparam logic [6:0] S2   = 7'h24;
    localparam logic [6:0] S4   = 7'h19;
    localparam logic [6:0] S5   = 7'h12;
    localparam logic [6:0] S7   = 7'h78;
    localparam logic [6:0] S8   = 7'h00;
    localparam logic [6:0] S9   = 7'h10;
    localparam logic [6:0] SOFF = 7'h7F;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    localparam logic [6:0] T0 = SOFF;
`else
    localparam logic [6:0] T0 = S0;
`endif

    typedef struct {
        logic [6:0] cnt;
        logic [6:0] tens_seg;
        logic [6:0] ones_seg;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    seg7_count_display_if bus();

    seg7_count_display #(.pSCAN_DIV(SCAN), .pMAX_DISP(99)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic settle(input string name);
        bit done = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_settle"}, int'(done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic read_display(output logic [6:0] t, output logic [6:0] o, output bit ok);
        bit got_t = 1'b0;
        bit got_o = 1'b0;
        t = 'x;
        o = 'x;
        for (int i = 0; i < 4 * SCAN + 4; i++) begin
            @(negedge clk);
            if (bus.an_n == 2'b10) begin
                o = bus.seg_n;
                got_o = 1'b1;
            end else if (bus.an_n == 2'b01) begin
                t = bus.seg_n;
                got_t = 1'b1;
            end
            if (got_t && got_o) break;
        end
        ok = got_t && got_o;
    endtask

    task automatic check_display(input string name, input logic [6:0] et, input logic [6:0] eo);
        logic [6:0] t, o;
        bit ok;
        read_display(t, o, ok);
        chk({name, "_scan_seen"}, int'(ok), 1);
        chk({name, "_tens"}, int'(t), int'(et));
        chk({name, "_ones"}, int'(o), int'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int run_len[4];
        int nruns;
        int both_on;
        logic [1:0] prev_an;

        vecs[0] = '{7'd99,  S9, S9, 1'b0};
        vecs[1] = '{7'd7,   T0, S7, 1'b0};
        vecs[2] = '{7'd120, S9, S9, 1'b1};
        vecs[3] = '{7'd42,  S4, S2, 1'b0};
        vecs[4] = '{7'd1,   T0, S1, 1'b0};
        vecs[5] = '{7'd0,   T0, S0, 1'b0};
        vecs[6] = '{7'd99,  S9, S9, 1'b0};
        vecs[7] = '{7'd100, S9, S9, 1'b1};
        vecs[8] = '{7'd58,  S5, S8, 1'b0};
        vecs[9] = '{7'd10,  S1, S0, 1'b0};

        // Reset with 99 held, first display exactly 10 clocks after release
        rst = 1'b1;
        bus.count_in = 7'd99;
        repeat (2) @(negedge clk);
        chk("rst_seg_n", int'(bus.seg_n), 'h7F);
        chk("rst_an_n",  int'(bus.an_n), 3);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_ovf",   int'(bus.ovf), 0);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        chk("first_busy_clk9", int'(bus.busy), 1);
        @(negedge clk);
        chk("first_busy_clk10", int'(bus.busy), 0);
        chk("first_ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        check_display("first99", S9, S9);

        // Scan pattern with count 7
        bus.count_in = 7'd7;
        settle("scan7");
        both_on = 0;
        nruns = 0;
        for (int k = 0; k < 4; k++) run_len[k] = 0;
        prev_an = bus.an_n;
        for (int i = 0; i < 6 * SCAN; i++) begin
            @(negedge clk);
            if (bus.an_n != 2'b10 && bus.an_n != 2'b01) both_on++;
            if (bus.an_n != prev_an) begin
                if (nruns < 4) nruns++;
            end else if (nruns > 0 && nruns < 4) begin
                run_len[nruns]++;
            end
            prev_an = bus.an_n;
        end
        chk("scan_only_one_digit", both_on, 0);
        chk("scan_run1_len", run_len[1] + 1, SCAN);
        chk("scan_run2_len", run_len[2] + 1, SCAN);
        check_display("scan7", T0, S7);

        // Table-driven values
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.count_in = vecs[i].cnt;
            settle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ovf", i), int'(bus.ovf), int'(vecs[i].ovf));
            check_display($sformatf("vec%0d", i), vecs[i].tens_seg, vecs[i].ones_seg);
        end

        // Exact ovf latency: change sampled at next edge, result 10 edges later
        @(negedge clk);
        bus.count_in = 7'd120;
        repeat (9) @(negedge clk);
        chk("lat_ovf_clk9", int'(bus.ovf), 0);
        chk("lat_busy_clk9", int'(bus.busy), 1);
        @(negedge clk);
        chk("lat_ovf_clk10", int'(bus.ovf), 1);
        chk("lat_busy_clk10", int'(bus.busy), 0);
        repeat (2) @(negedge clk);
        check_display("lat120", S9, S9);

        // Back-to-back steps 99,98,97
        bus.count_in = 7'd99;
        @(negedge clk);
        bus.count_in = 7'd98;
        @(negedge clk);
        bus.count_in = 7'd97;
        settle("steps");
        repeat (12) @(negedge clk);
        chk("steps_busy_idle", int'(bus.busy), 0);
        chk("steps_ovf", int'(bus.ovf), 0);
        check_display("steps97", S9, S7);

        // Reset mid-conversion
        @(negedge clk);
        bus.count_in = 7'd42;
        repeat (4) @(negedge clk);
        chk("midrst_in_conv", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_seg_n", int'(bus.seg_n), 'h7F);
        chk("midrst_an_n", int'(bus.an_n), 3);
        chk("midrst_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_clk9", int'(bus.busy), 1);
        @(negedge clk);
        chk("midrst_busy_clk10", int'(bus.busy), 0);
        chk("midrst_ovf", int'(bus.ovf), 0);
        repeat (2) @(negedge clk);
        check_display("midrst42", S4, S2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
